// File: rtl/pvt_result_uart_tx.sv
// pvt_result_uart_tx: serial readout of PVT monitor records.
// Takes one {id, count} record over valid/ready and sends it as a
// 5-byte UART 8N1 packet: A5, {5'b0,id}, data[15:8], data[7:0], xor.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous reset, active-high
//   in_valid   - record offered by the monitor core
//   in_ready   - idle and not in reset; record accepted on valid&ready
//   in_id      - 3-bit sensor id of the offered record
//   in_data    - 16-bit measurement count of the offered record
//   tx         - UART line, idle high, driven from a register
//   busy       - high for exactly the cycles the packet is on tx
//   frame_done - one-cycle pulse in the idle cycle after the last stop bit

module pvt_result_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_id,
    input  logic [15:0] in_data,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [2:0] LAST_BYTE = 3'd4;
    localparam logic [2:0] LAST_BIT = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;
    logic [BW-1:0]  r_baud;
    logic [BW-1:0]  w_baud_nx;
    logic [2:0]     r_bit;
    logic [2:0]     w_bit_nx;
    logic [2:0]     r_byte;
    logic [2:0]     w_byte_nx;
    logic [2:0]     r_id;
    logic [2:0]     w_id_nx;
    logic [15:0]    r_data;
    logic [15:0]    w_data_nx;
    logic           r_tx;
    logic           w_tx_nx;
    logic           r_done;
    logic           w_done_nx;

    logic           w_accept;
    logic           w_baud_end;
    logic [2:0]     w_bit_inc;
    logic [7:0]     w_b1;
    logic [7:0]     w_b2;
    logic [7:0]     w_b3;
    logic [7:0]     w_cur;

    assign in_ready   = (r_state == S_IDLE) & ~rst;
    assign w_accept   = in_valid & in_ready;
    assign w_baud_end = (r_baud == BAUD_MAX);
    assign w_bit_inc  = r_bit + 3'd1;

    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_done;

    // Packet bytes are built from the captured record only, so the
    // inputs may change freely once the record has been accepted.
    assign w_b1 = {5'b0, r_id};
    assign w_b2 = r_data[15:8];
    assign w_b3 = r_data[7:0];

    always_comb begin
        w_cur = SYNC_BYTE;
        case (r_byte)
            3'd0:    w_cur = SYNC_BYTE;
            3'd1:    w_cur = w_b1;
            3'd2:    w_cur = w_b2;
            3'd3:    w_cur = w_b3;
            3'd4:    w_cur = w_b1 ^ w_b2 ^ w_b3;
            default: w_cur = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_id    <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_baud  <= w_baud_nx;
            r_bit   <= w_bit_nx;
            r_byte  <= w_byte_nx;
            r_id    <= w_id_nx;
            r_data  <= w_data_nx;
            r_tx    <= w_tx_nx;
            r_done  <= w_done_nx;
        end
    end

    // tx is computed one cycle ahead here so the pin itself is a flop:
    // each branch sets the level of the bit that starts next cycle.
    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud;
        w_bit_nx   = r_bit;
        w_byte_nx  = r_byte;
        w_id_nx    = r_id;
        w_data_nx  = r_data;
        w_tx_nx    = r_tx;
        w_done_nx  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_tx_nx = 1'b1;
                if (w_accept) begin
                    w_state_nx = S_START;
                    w_id_nx    = in_id;
                    w_data_nx  = in_data;
                    w_baud_nx  = '0;
                    w_bit_nx   = '0;
                    w_byte_nx  = '0;
                    w_tx_nx    = 1'b0;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_state_nx = S_DATA;
                    w_baud_nx  = '0;
                    w_bit_nx   = '0;
                    w_tx_nx    = w_cur[0];
                end else begin
                    w_baud_nx = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nx = '0;
                    if (r_bit == LAST_BIT) begin
                        w_state_nx = S_STOP;
                        w_bit_nx   = '0;
                        w_tx_nx    = 1'b1;
                    end else begin
                        w_bit_nx = w_bit_inc;
                        w_tx_nx  = w_cur[w_bit_inc];
                    end
                end else begin
                    w_baud_nx = r_baud + 1'b1;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nx = '0;
                    if (r_byte == LAST_BYTE) begin
                        w_state_nx = S_IDLE;
                        w_byte_nx  = '0;
                        w_tx_nx    = 1'b1;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = S_START;
                        w_byte_nx  = r_byte + 3'd1;
                        w_tx_nx    = 1'b0;
                    end
                end else begin
                    w_baud_nx = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_tx_nx    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pvt_result_uart_tx.sv
// tb_pvt_result_uart_tx: directed bench for pvt_result_uart_tx.
// Two instances: CLKS_PER_BIT=4 (main) and CLKS_PER_BIT=2.

module tb_pvt_result_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v4 = 1'b0;
    logic        v2 = 1'b0;
    logic [2:0]  in_id = '0;
    logic [15:0] in_data = '0;
    logic        ready4, tx4, busy4, fd4;
    logic        ready2, tx2, busy2, fd2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pvt_result_uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (v4),
        .in_ready   (ready4),
        .in_id      (in_id),
        .in_data    (in_data),
        .tx         (tx4),
        .busy       (busy4),
        .frame_done (fd4)
    );

    pvt_result_uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (v2),
        .in_ready   (ready2),
        .in_id      (in_id),
        .in_data    (in_data),
        .tx         (tx2),
        .busy       (busy2),
        .frame_done (fd2)
    );

    typedef struct {
        logic [2:0]  id;
        logic [15:0] data;
        logic [39:0] pkt;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic get_tx(input int w);
        return (w == 2) ? tx2 : tx4;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 2) ? busy2 : busy4;
    endfunction

    function automatic logic get_fd(input int w);
        return (w == 2) ? fd2 : fd4;
    endfunction

    task automatic send(input int w, input logic [2:0] id,
                        input logic [15:0] d);
        @(negedge clk);
        in_id   = id;
        in_data = d;
        if (w == 2) v2 = 1'b1;
        else v4 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        v4 = 1'b0;
    endtask

    // Samples tx once per cycle from the first low cycle; returns at
    // the frame_done cycle (or after a bounded wait).
    task automatic capture(input int w, input int cpb,
                           output logic [39:0] pk, output int fd_lat,
                           output int wait_cyc, output int bad_frame,
                           output int bad_busy);
        logic s;
        logic prev;
        int idx, pos, b, k;
        pk = 'x;
        fd_lat = -1;
        wait_cyc = 0;
        bad_frame = 0;
        bad_busy = 0;
        prev = 1'b1;
        while (get_tx(w) !== 1'b0 && wait_cyc < 1000) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (get_tx(w) !== 1'b0) return;
        pk = '0;
        for (int c = 0; c < 50 * cpb; c++) begin
            s = get_tx(w);
            idx = c / cpb;
            pos = c % cpb;
            b = idx / 10;
            k = idx % 10;
            if (get_busy(w) !== 1'b1 || get_fd(w) !== 1'b0) bad_busy++;
            if (pos == 0) begin
                if (k == 0 && s !== 1'b0) bad_frame++;
                else if (k == 9 && s !== 1'b1) bad_frame++;
                else if (k > 0 && k < 9) pk[(4 - b) * 8 + k - 1] = s;
            end else if (s !== prev) begin
                bad_frame++;
            end
            prev = s;
            @(negedge clk);
        end
        fd_lat = 50 * cpb;
        while (get_fd(w) !== 1'b1 && fd_lat < 50 * cpb + 8) begin
            @(negedge clk);
            fd_lat++;
        end
    endtask

    logic [39:0] pk;
    int fd_lat, wc, bf, bb, cnt;

    initial begin
        vecs[0] = '{3'd3, 16'h1234, 40'hA5_03_12_34_25};
        vecs[1] = '{3'd7, 16'hFFFF, 40'hA5_07_FF_FF_07};
        vecs[2] = '{3'd0, 16'h0000, 40'hA5_00_00_00_00};
        vecs[3] = '{3'd5, 16'hA55A, 40'hA5_05_A5_5A_FA};
        vecs[4] = '{3'd2, 16'h0F0F, 40'hA5_02_0F_0F_02};

        repeat (3) @(negedge clk);
        chk("rst_tx", tx4, 1'b1);
        chk("rst_busy", busy4, 1'b0);
        chk("rst_fd", fd4, 1'b0);
        chk("rst_ready_low", ready4, 1'b0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", ready4, 1'b1);
        chk("ready2_after_rst", ready2, 1'b1);

        for (int i = 0; i < 5; i++) begin
            send(4, vecs[i].id, vecs[i].data);
            capture(4, 4, pk, fd_lat, wc, bf, bb);
            chk($sformatf("pkt[%0d]", i), pk, vecs[i].pkt);
            chk($sformatf("fd_lat[%0d]", i), fd_lat, 200);
            chk($sformatf("first_low[%0d]", i), wc, 0);
            chk($sformatf("framing[%0d]", i), bf, 0);
            chk($sformatf("busy_win[%0d]", i), bb, 0);
            chk($sformatf("fd_tx[%0d]", i), tx4, 1'b1);
            chk($sformatf("fd_busy[%0d]", i), busy4, 1'b0);
            chk($sformatf("fd_ready[%0d]", i), ready4, 1'b1);
        end

        // Back-to-back: valid held, second record taken in frame_done cycle.
        @(negedge clk);
        in_id = 3'd6;
        in_data = 16'hBEEF;
        v4 = 1'b1;
        @(negedge clk);
        in_id = 3'd1;
        in_data = 16'h00FF;
        capture(4, 4, pk, fd_lat, wc, bf, bb);
        chk("b2b_pktA", pk, 40'hA5_06_BE_EF_57);
        chk("b2b_fdA", fd_lat, 200);
        chk("b2b_gap_tx", tx4, 1'b1);
        @(negedge clk);
        v4 = 1'b0;
        chk("b2b_restart", tx4, 1'b0);
        capture(4, 4, pk, fd_lat, wc, bf, bb);
        chk("b2b_pktB", pk, 40'hA5_01_00_FF_FE);
        chk("b2b_waitB", wc, 0);
        chk("b2b_frameB", bf + bb, 0);

        // Inputs and valid pulse mid-packet must not disturb it.
        send(4, 3'd4, 16'h8001);
        fork
            capture(4, 4, pk, fd_lat, wc, bf, bb);
            begin
                repeat (60) @(negedge clk);
                in_id = 3'd7;
                in_data = 16'hDEAD;
                v4 = 1'b1;
                #1;
                chk("busy_ready_low", ready4, 1'b0);
                @(negedge clk);
                v4 = 1'b0;
            end
        join
        chk("ignore_pkt", pk, 40'hA5_04_80_01_85);
        chk("ignore_fd", fd_lat, 200);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx4 !== 1'b1 || busy4 !== 1'b0) cnt++;
        end
        chk("no_extra_pkt", cnt, 0);

        // Reset in byte 2, bit 3 (cycle index 96..99).
        send(4, 3'd3, 16'h1234);
        repeat (97) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx4, 1'b1);
        chk("abort_busy", busy4, 1'b0);
        chk("abort_fd", fd4, 1'b0);
        chk("abort_ready_in_rst", ready4, 1'b0);
        rst = 1'b0;
        #1;
        chk("abort_ready", ready4, 1'b1);
        cnt = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (fd4 !== 1'b0 || tx4 !== 1'b1) cnt++;
        end
        chk("abort_quiet", cnt, 0);
        send(4, 3'd2, 16'hC3A0);
        capture(4, 4, pk, fd_lat, wc, bf, bb);
        chk("post_abort_pkt", pk, 40'hA5_02_C3_A0_61);
        chk("post_abort_fd", fd_lat, 200);
        chk("post_abort_frame", bf + bb, 0);

        // Two clocks per bit.
        send(2, 3'd3, 16'h1234);
        capture(2, 2, pk, fd_lat, wc, bf, bb);
        chk("cpb2_pkt", pk, 40'hA5_03_12_34_25);
        chk("cpb2_len", fd_lat, 100);
        chk("cpb2_frame", bf + bb, 0);
        chk("cpb2_fd_tx", tx2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
